// File: rtl/attn_pkg.sv
`default_nettype none
// ============================================================
// attn_pkg : shared geometry and collector state encoding
// Rev 1.0
// ============================================================
package attn_pkg;

  localparam int ROWS        = 4;
  localparam int GROUPS      = 32;
  localparam int DEPTH       = ROWS * GROUPS;
  localparam int ADDR_W      = 7;
  localparam int DATA_W      = 128;
  localparam int TRACK_CNT_W = 8;

  typedef enum logic [1:0] {
    C_IDLE    = 2'd0,
    C_COLLECT = 2'd1,
    C_DRAIN   = 2'd2,
    C_DONE    = 2'd3
  } coll_state_e;

endpackage
`default_nettype wire

// File: rtl/attn_skid_fifo.sv
`default_nettype none
// ============================================================
// attn_skid_fifo : small synchronous FIFO buffering SRAM
//   return data in front of the drain consumer
// Rev 1.0
// ============================================================
module attn_skid_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 128,
  localparam int CNT_W = $clog2(DEPTH + 1),
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty,
  output logic [CNT_W-1:0] count
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push, do_pop;

  assign empty   = (count_q == '0);
  assign full    = (count_q == CNT_W'(DEPTH));
  assign count   = count_q;
  assign dout    = mem_q[rd_ptr_q];
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) begin
      wr_ptr_d = (wr_ptr_q == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr_q + PTR_W'(1);
    end
    if (do_pop) begin
      rd_ptr_d = (rd_ptr_q == PTR_W'(DEPTH - 1)) ? '0 : rd_ptr_q + PTR_W'(1);
    end
    if (do_push && !do_pop) begin
      count_d = count_q + CNT_W'(1);
    end else if (!do_push && do_pop) begin
      count_d = count_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage is not reset; the consumer gates dout with empty.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= din;
    end
  end

endmodule
`default_nettype wire

// File: rtl/attn_out_collector.sv
`default_nettype none
// ============================================================
// attn_out_collector : writes attention-output beats into the
//   O SRAM, then drains all entries in address order.
//   Build option ATTN_OUT_DUP_CHECK_EN: bitmap tracking with
//   duplicate detection (default: beat counter).
// Rev 1.0
// ============================================================
module attn_out_collector
  import attn_pkg::*;
#(
  parameter int READ_LAT = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              arm,
  input  logic              in_valid,
  input  logic [1:0]        in_row,
  input  logic [4:0]        in_group,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_done,
  output logic [ADDR_W-1:0] O_mem_addr,
  output logic              O_mem_wen,
  output logic              O_mem_ren,
  output logic [DATA_W-1:0] O_mem_din,
  input  logic [DATA_W-1:0] O_mem_out,
  output logic              rd_valid,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_last,
  input  logic              rd_ready,
  output logic              busy,
  output logic              done,
  output logic              err
);

  localparam int                FIFO_DEPTH = READ_LAT + 2;
  localparam int                CNT_W      = $clog2(FIFO_DEPTH + 1);
  localparam logic [ADDR_W:0]   RD_END     = (ADDR_W + 1)'(DEPTH);
  localparam logic [ADDR_W-1:0] LAST_ADDR  = ADDR_W'(DEPTH - 1);

  coll_state_e         state_q, state_d;
  logic                err_q, err_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                wen_q, wen_d;
  logic                ren_q, ren_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   din_q, din_d;
  logic [ADDR_W:0]     raddr_q, raddr_d;
  logic [ADDR_W-1:0]   pop_cnt_q, pop_cnt_d;
  logic [READ_LAT-1:0] rpipe_q, rpipe_d;

`ifdef ATTN_OUT_DUP_CHECK_EN
  logic [DEPTH-1:0]    wmap_q, wmap_d;
  logic [DEPTH-1:0]    wmap_beat;
`else
  logic [TRACK_CNT_W-1:0] wcnt_q, wcnt_d;
  logic [TRACK_CNT_W-1:0] wcnt_beat;
`endif

  logic [ADDR_W-1:0]   beat_addr;
  logic                beat_dup, complete;
  logic                track_clr, track_upd;
  logic                fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [CNT_W-1:0]    fifo_count;
  logic [DATA_W-1:0]   fifo_dout;
  logic [7:0]          inflight, free_slots;

  assign beat_addr = {in_row, in_group};
  assign track_clr = (state_q == C_IDLE) && arm;
  assign track_upd = (state_q == C_COLLECT) && in_valid;

  // Completeness includes a beat arriving alongside in_done.
`ifdef ATTN_OUT_DUP_CHECK_EN
  always_comb begin
    wmap_beat = wmap_q;
    if (in_valid) begin
      wmap_beat[beat_addr] = 1'b1;
    end
    beat_dup = in_valid && wmap_q[beat_addr];
    complete = &wmap_beat;
    wmap_d   = track_clr ? '0 : (track_upd ? wmap_beat : wmap_q);
  end
`else
  always_comb begin
    wcnt_beat = wcnt_q + TRACK_CNT_W'(in_valid);
    beat_dup  = 1'b0;
    complete  = (wcnt_beat == TRACK_CNT_W'(DEPTH));
    wcnt_d    = track_clr ? '0 : (track_upd ? wcnt_beat : wcnt_q);
  end
`endif

  // A read may issue only if every outstanding return still has a slot.
  always_comb begin
    inflight = 8'(ren_q);
    for (int i = 0; i < READ_LAT; i++) begin
      inflight = inflight + 8'(rpipe_q[i]);
    end
    free_slots = 8'(FIFO_DEPTH) - 8'(fifo_count);
    rpipe_d    = rpipe_q;
    rpipe_d[0] = ren_q;
    for (int i = 1; i < READ_LAT; i++) begin
      rpipe_d[i] = rpipe_q[i-1];
    end
  end

  assign fifo_push = rpipe_q[READ_LAT-1];
  assign rd_valid  = !fifo_empty;
  assign fifo_pop  = rd_valid && rd_ready;
  assign rd_data   = rd_valid ? fifo_dout : '0;
  assign rd_last   = rd_valid && (pop_cnt_q == LAST_ADDR);

  always_comb begin
    state_d   = state_q;
    err_d     = err_q;
    wen_d     = 1'b0;
    ren_d     = 1'b0;
    addr_d    = addr_q;
    din_d     = din_q;
    raddr_d   = raddr_q;
    pop_cnt_d = fifo_pop ? pop_cnt_q + ADDR_W'(1) : pop_cnt_q;
    case (state_q)
      C_IDLE: begin
        if (arm) begin
          state_d   = C_COLLECT;
          err_d     = 1'b0;
          raddr_d   = '0;
          pop_cnt_d = '0;
        end
      end
      C_COLLECT: begin
        if (in_valid) begin
          wen_d  = 1'b1;
          addr_d = beat_addr;
          din_d  = in_data;
          if (beat_dup) begin
            err_d = 1'b1;
          end
        end
        if (in_done) begin
          state_d = C_DRAIN;
          if (!complete) begin
            err_d = 1'b1;
          end
        end
      end
      C_DRAIN: begin
        if (in_valid) begin
          err_d = 1'b1;
        end
        if ((raddr_q != RD_END) && (free_slots > inflight) && !fifo_full) begin
          ren_d   = 1'b1;
          addr_d  = raddr_q[ADDR_W-1:0];
          raddr_d = raddr_q + (ADDR_W + 1)'(1);
        end
        if (fifo_pop && rd_last) begin
          state_d = C_DONE;
        end
      end
      C_DONE: begin
        if (in_valid) begin
          err_d = 1'b1;
        end
        state_d = C_IDLE;
      end
      default: state_d = C_IDLE;
    endcase
    busy_d = (state_d == C_COLLECT) || (state_d == C_DRAIN);
    done_d = (state_d == C_DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= C_IDLE;
      err_q     <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      wen_q     <= 1'b0;
      ren_q     <= 1'b0;
      addr_q    <= '0;
      din_q     <= '0;
      raddr_q   <= '0;
      pop_cnt_q <= '0;
      rpipe_q   <= '0;
`ifdef ATTN_OUT_DUP_CHECK_EN
      wmap_q    <= '0;
`else
      wcnt_q    <= '0;
`endif
    end else begin
      state_q   <= state_d;
      err_q     <= err_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      wen_q     <= wen_d;
      ren_q     <= ren_d;
      addr_q    <= addr_d;
      din_q     <= din_d;
      raddr_q   <= raddr_d;
      pop_cnt_q <= pop_cnt_d;
      rpipe_q   <= rpipe_d;
`ifdef ATTN_OUT_DUP_CHECK_EN
      wmap_q    <= wmap_d;
`else
      wcnt_q    <= wcnt_d;
`endif
    end
  end

  attn_skid_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (DATA_W)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (fifo_push),
    .din   (O_mem_out),
    .pop   (fifo_pop),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  assign O_mem_addr = addr_q;
  assign O_mem_wen  = wen_q;
  assign O_mem_ren  = ren_q;
  assign O_mem_din  = din_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign err        = err_q;

endmodule
`default_nettype wire

// File: tb/tb_attn_out_collector.sv
`default_nettype none
// ============================================================
// tb_attn_out_collector : directed self-checking bench with a
//   behavioural O SRAM of fixed read latency
// Rev 1.0
// ============================================================
module tb_attn_out_collector;

  localparam int LAT = 3;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         arm = 1'b0;
  logic         in_valid = 1'b0;
  logic [1:0]   in_row = '0;
  logic [4:0]   in_group = '0;
  logic [127:0] in_data = '0;
  logic         in_done = 1'b0;
  logic         rd_ready = 1'b0;
  logic [6:0]   O_mem_addr;
  logic         O_mem_wen, O_mem_ren;
  logic [127:0] O_mem_din, O_mem_out;
  logic         rd_valid, rd_last, busy, done, err;
  logic [127:0] rd_data;

  attn_out_collector #(.READ_LAT(LAT)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .arm        (arm),
    .in_valid   (in_valid),
    .in_row     (in_row),
    .in_group   (in_group),
    .in_data    (in_data),
    .in_done    (in_done),
    .O_mem_addr (O_mem_addr),
    .O_mem_wen  (O_mem_wen),
    .O_mem_ren  (O_mem_ren),
    .O_mem_din  (O_mem_din),
    .O_mem_out  (O_mem_out),
    .rd_valid   (rd_valid),
    .rd_data    (rd_data),
    .rd_last    (rd_last),
    .rd_ready   (rd_ready),
    .busy       (busy),
    .done       (done),
    .err        (err)
  );

  always #5 clk = ~clk;

  // Behavioural SRAM: data for a read appears LAT cycles after ren.
  logic [127:0] sram  [128];
  logic [127:0] rpipe [LAT];
  int           overlap_cnt = 0;

  always @(posedge clk) begin
    if (O_mem_wen) sram[O_mem_addr] <= O_mem_din;
    rpipe[0] <= O_mem_ren ? sram[O_mem_addr] : '0;
    for (int i = 1; i < LAT; i++) rpipe[i] <= rpipe[i-1];
    if (O_mem_wen && O_mem_ren) overlap_cnt <= overlap_cnt + 1;
  end
  assign O_mem_out = rpipe[LAT-1];

  logic [127:0] exp_mem [128];
  logic [127:0] got     [128];
  int n_vec = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] expv);
    n_vec++;
    if (obs !== expv) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, expv);
    end
  endtask

  function automatic logic [127:0] pat(input int set, input int a);
    logic [31:0] w;
    w = 32'((set << 16) | a);
    return (set == 0) ? 128'(a) : {4{w}};
  endfunction

  task automatic do_arm();
    arm = 1'b1;
    @(posedge clk); #1;
    arm = 1'b0;
  endtask

  task automatic beat(input int a, input logic [127:0] d, input logic with_done);
    logic [6:0] av;
    av       = 7'(a);
    in_valid = 1'b1;
    in_row   = av[6:5];
    in_group = av[4:0];
    in_data  = d;
    in_done  = with_done;
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_done  = 1'b0;
    exp_mem[a] = d;
  endtask

  task automatic pulse_done();
    in_done = 1'b1;
    @(posedge clk); #1;
    in_done = 1'b0;
  endtask

  task automatic run_drain(input int mode, input int stop_at,
                           output int nb, output int bad_data, output int bad_last,
                           output int bad_stall, output logic saw_done);
    int           cyc;
    logic         stalled;
    logic [127:0] held;
    cyc = 0; nb = 0; bad_data = 0; bad_last = 0; bad_stall = 0;
    saw_done = 1'b0; stalled = 1'b0; held = '0;
    while (cyc < 2000 && !saw_done && !(stop_at > 0 && nb == stop_at)) begin
      rd_ready = (mode == 0) ? 1'b1 : ((cyc % 3) == 0);
      @(negedge clk);
      if (done) saw_done = 1'b1;
      if (stalled && (!rd_valid || rd_data !== held)) bad_stall++;
      if (rd_valid && rd_ready) begin
        if (nb >= 128) bad_data++;
        else begin
          got[nb] = rd_data;
          if (rd_data !== exp_mem[nb]) bad_data++;
          if (rd_last !== (nb == 127)) bad_last++;
        end
        nb++;
        stalled = 1'b0;
      end else begin
        stalled = rd_valid;
        held    = rd_data;
      end
      @(posedge clk); #1;
      cyc++;
    end
    rd_ready = 1'b0;
  endtask

  task automatic full_drain(input string tag, input int mode, input logic exp_err);
    int   nb, bd, bl, bs;
    logic sd;
    run_drain(mode, 0, nb, bd, bl, bs, sd);
    chk({tag, "_beats"}, 128'(nb), 128'd128);
    chk({tag, "_data"}, 128'(bd), '0);
    chk({tag, "_last"}, 128'(bl), '0);
    chk({tag, "_stall"}, 128'(bs), '0);
    chk({tag, "_done_seen"}, 128'(sd), 128'd1);
    @(negedge clk);
    chk({tag, "_done_pulse_end"}, {126'd0, done, busy}, '0);
    chk({tag, "_err"}, 128'(err), 128'(exp_err));
    @(posedge clk); #1;
  endtask

  initial begin
    int   nb, bd, bl, bs, act;
    logic sd;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_ctl", {121'd0, busy, done, err, rd_valid, rd_last, O_mem_wen, O_mem_ren}, '0);
    chk("rst_addr_din", {O_mem_addr, O_mem_din[120:0]}, '0);
    chk("rst_rd_data", rd_data, '0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Beat while idle: no write, no error.
    in_valid = 1'b1; in_row = 2'd1; in_group = 5'd2; in_data = '1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(negedge clk);
    chk("idle_beat", {126'd0, O_mem_wen, err}, '0);
    @(posedge clk); #1;

    // Full row-major stream, free-running consumer.
    do_arm();
    chk("arm_busy", 128'(busy), 128'd1);
    for (int a = 0; a < 128; a++) begin
      beat(a, pat(0, a), 1'b0);
      if (a == 37) begin
        chk("wr_beat37", {O_mem_wen, O_mem_addr, O_mem_din[15:0]}, {1'b1, 7'd37, 16'd37});
      end
    end
    pulse_done();
    chk("t1_err_after_done", {126'd0, busy, err}, 128'b10);
    full_drain("t1", 0, 1'b0);

    // Same stream shape, consumer ready one cycle in three.
    do_arm();
    for (int a = 0; a < 128; a++) beat(a, pat(1, a), 1'b0);
    pulse_done();
    full_drain("t2", 1, 1'b0);

    // Missing entry 127: error, but all 128 entries still drain.
    do_arm();
    for (int a = 0; a < 127; a++) beat(a, pat(2, a), 1'b0);
    pulse_done();
    chk("t3_err_incomplete", 128'(err), 128'd1);
    full_drain("t3", 0, 1'b1);

    // Entry 5 written twice; second value must win. Arm clears err.
    do_arm();
    chk("t4_arm_clears_err", 128'(err), '0);
    for (int a = 0; a < 128; a++) beat(a, (a == 5) ? 128'hA : pat(3, a), 1'b0);
    beat(5, 128'hB, 1'b0);
    pulse_done();
    chk("t4_err_dup", 128'(err), 128'd1);
    full_drain("t4", 0, 1'b1);
    chk("t4_entry5", got[5], 128'hB);

    // Final beat alongside in_done; stray beat during drain.
    do_arm();
    for (int a = 0; a < 127; a++) beat(a, pat(4, a), 1'b0);
    beat(127, pat(4, 127), 1'b1);
    chk("t5_done_beat", {126'd0, busy, err}, 128'b10);
    in_valid = 1'b1; in_row = 2'd0; in_group = 5'd3; in_data = 128'hDEAD;
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("t5_err_stray", {126'd0, O_mem_wen, err}, 128'b01);
    full_drain("t5", 0, 1'b1);

    // Reset in the middle of a drain.
    do_arm();
    for (int a = 0; a < 128; a++) beat(a, pat(5, a), 1'b0);
    pulse_done();
    run_drain(0, 40, nb, bd, bl, bs, sd);
    chk("t6_partial", {64'(nb), 64'(bd)}, {64'd40, 64'd0});
    rst_n = 1'b0;
    @(negedge clk);
    chk("t6_rst_ctl", {121'd0, busy, done, err, rd_valid, rd_last, O_mem_wen, O_mem_ren}, '0);
    chk("t6_rst_data", rd_data | O_mem_din | 128'(O_mem_addr), '0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n    = 1'b1;
    rd_ready = 1'b1;
    act      = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (rd_valid || O_mem_ren || O_mem_wen || busy) act++;
    end
    rd_ready = 1'b0;
    chk("t6_no_stale", 128'(act), '0);

    chk("wen_ren_excl", 128'(overlap_cnt), '0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
